// File: rtl/fast_thr_frame_ctrl_if.sv
// fast_thr_frame_ctrl_if: datapath-facing signals of the FAST frame controller.
// master = datapath side, slave = controller side.
interface fast_thr_frame_ctrl_if;
    logic       TVALID_in;
    logic       in_V_SYNC;
    logic       in_data_en;
    logic       Feature_val;
    logic [7:0] threshold;

    modport master (
        output TVALID_in, in_V_SYNC, in_data_en, Feature_val,
        input  threshold
    );

    modport slave (
        input  TVALID_in, in_V_SYNC, in_data_en, Feature_val,
        output threshold
    );
endinterface

// File: rtl/fast_thr_frame_ctrl.sv
// fast_thr_frame_ctrl: per-frame FAST feature counter and threshold driver.
// Define FAST_AUTO_THR_EN to steer the threshold toward cfg_target each frame.
module fast_thr_frame_ctrl #(
    parameter int CNT_W   = 20,
    parameter int THR_MIN = 8,
    parameter int THR_MAX = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fast_thr_frame_ctrl_if.slave dp,
    input  logic [7:0]           cfg_thr_init,
    input  logic [CNT_W-1:0]     cfg_target,
    input  logic [CNT_W-1:0]     cfg_tol,
    input  logic [7:0]           cfg_step,
    input  logic                 cfg_enable,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 frame_done,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        UPDATE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]       threshold_q, threshold_d;
    logic             frame_done_q, frame_done_d;
    logic             vs_q, vs_d;

    logic             start;
    logic             feat;
    logic [CNT_W-1:0] cnt_sat;
    logic [7:0]       thr_upd;

    // Edge register only moves on valid cycles so stalls cannot fake an edge.
    assign start = dp.TVALID_in & dp.in_V_SYNC & ~vs_q;
    assign feat  = dp.TVALID_in & dp.in_data_en & dp.Feature_val;
    assign vs_d  = dp.TVALID_in ? dp.in_V_SYNC : vs_q;

    assign cnt_sat = (feat && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef FAST_AUTO_THR_EN
    localparam logic [7:0] THR_MIN8 = 8'(THR_MIN);
    localparam logic [7:0] THR_MAX8 = 8'(THR_MAX);
    localparam logic [8:0] THR_MAX9 = 9'(THR_MAX);

    logic [CNT_W:0] cnt_w;
    logic [CNT_W:0] hi_w;
    logic [CNT_W:0] lo_w;
    logic [8:0]     up_w;
    logic [7:0]     dn_w;

    always_comb begin
        cnt_w   = {1'b0, cnt_q};
        hi_w    = {1'b0, cfg_target} + {1'b0, cfg_tol};
        lo_w    = {1'b0, cfg_target} - {1'b0, cfg_tol};
        up_w    = {1'b0, threshold_q} + {1'b0, cfg_step};
        dn_w    = threshold_q - cfg_step;
        thr_upd = threshold_q;
        if (cnt_w > hi_w) begin
            thr_upd = (up_w > THR_MAX9) ? THR_MAX8 : up_w[7:0];
        end else if (cfg_target >= cfg_tol && cnt_w < lo_w) begin
            if (cfg_step > threshold_q || dn_w < THR_MIN8) begin
                thr_upd = THR_MIN8;
            end else begin
                thr_upd = dn_w;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_target, cfg_tol, cfg_step};
    assign thr_upd    = cfg_thr_init;
`endif

    // The closing frame's results are latched on the start edge so that
    // frame_done, frame_cnt and the new threshold all appear in UPDATE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_cnt_d  = frame_cnt_q;
        threshold_d  = threshold_q;
        frame_done_d = 1'b0;
        if (!cfg_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    if (start) begin
                        threshold_d = cfg_thr_init;
                        cnt_d       = '0;
                        state_d     = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (start) begin
                        frame_cnt_d  = cnt_q;
                        frame_done_d = 1'b1;
                        threshold_d  = thr_upd;
                        cnt_d        = {{(CNT_W-1){1'b0}}, feat};
                        state_d      = UPDATE;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                UPDATE: begin
                    cnt_d   = cnt_sat;
                    state_d = ACTIVE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_cnt_q  <= '0;
            threshold_q  <= '0;
            frame_done_q <= 1'b0;
            vs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            threshold_q  <= threshold_d;
            frame_done_q <= frame_done_d;
            vs_q         <= vs_d;
        end
    end

    assign dp.threshold = threshold_q;
    assign frame_cnt    = frame_cnt_q;
    assign frame_done   = frame_done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fast_thr_frame_ctrl.sv
// tb_fast_thr_frame_ctrl: random frames against a frame-level reference model.
// Expected threshold rule follows FAST_AUTO_THR_EN like the design.
module tb_fast_thr_frame_ctrl;

    localparam int CNT_W   = 10;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int THR_MIN = 8;
    localparam int THR_MAX = 200;
`ifdef FAST_AUTO_THR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       cfg_thr_init;
    logic [CNT_W-1:0] cfg_target;
    logic [CNT_W-1:0] cfg_tol;
    logic [7:0]       cfg_step;
    logic             cfg_enable;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_done;
    logic [1:0]       state_o;

    fast_thr_frame_ctrl_if dp ();

    fast_thr_frame_ctrl #(
        .CNT_W  (CNT_W),
        .THR_MIN(THR_MIN),
        .THR_MAX(THR_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dp          (dp),
        .cfg_thr_init(cfg_thr_init),
        .cfg_target  (cfg_target),
        .cfg_tol     (cfg_tol),
        .cfg_step    (cfg_step),
        .cfg_enable  (cfg_enable),
        .frame_cnt   (frame_cnt),
        .frame_done  (frame_done),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: 0 = disabled, 1 = waiting for first frame, 2 = running.
    int m_mode, m_cnt, m_fcnt, m_thr, m_state;
    bit m_vs, m_done;

    int n_done, obs_fcnt, obs_thr;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_thr(input int thr, input int cnt);
        int t = int'(cfg_target);
        int l = int'(cfg_tol);
        int s = int'(cfg_step);
        int r = thr;
        if (cnt > t + l) r = (thr + s > THR_MAX) ? THR_MAX : thr + s;
        else if (t >= l && cnt < t - l) r = (thr - s < THR_MIN) ? THR_MIN : thr - s;
        return AUTO ? r : int'(cfg_thr_init);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_fcnt = 0; m_thr = 0;
        m_vs = 1'b0; m_done = 1'b0; m_state = 0;
    endtask

    task automatic model_edge(input bit tv, vs, de, fv);
        bit st = tv && vs && !m_vs;
        bit ft = tv && de && fv;
        if (tv) m_vs = vs;
        m_done = 1'b0;
        if (!cfg_enable) begin
            m_mode = 0;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (st) begin
                m_thr  = cfg_thr_init;
                m_cnt  = 0;
                m_mode = 2;
            end
        end else if (st) begin
            m_done = 1'b1;
            m_fcnt = m_cnt;
            m_thr  = next_thr(m_thr, m_cnt);
            m_cnt  = ft ? 1 : 0;
        end else if (ft) begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
        m_state = m_done ? 3 : m_mode;
    endtask

    task automatic step(input bit tv, vs, de, fv);
        @(negedge clk);
        dp.TVALID_in   = tv;
        dp.in_V_SYNC   = vs;
        dp.in_data_en  = de;
        dp.Feature_val = fv;
        @(posedge clk);
        model_edge(tv, vs, de, fv);
        #1;
        chk("done", frame_done, m_done);
        chk("thr", dp.threshold, m_thr);
        chk("fcnt", frame_cnt, m_fcnt);
        chk("state", state_o, m_state);
        if (frame_done) begin
            n_done++;
            obs_fcnt = frame_cnt;
            obs_thr  = dp.threshold;
        end
    endtask

    task automatic frame_start(input bit fs);
        step(1'b1, 1'b1, 1'b1, fs);
    endtask

    // n counts qualifying features of the new frame, including a start-cycle one.
    task automatic frame_body(input int n, input bit fs);
        int q = fs ? 1 : 0;
        bit tv, de, fv;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        while (q < n) begin
            tv = ($urandom % 8) != 0;
            de = ($urandom % 4) != 0;
            fv = $urandom % 2;
            step(tv, 1'b0, de, fv);
            if (tv && de && fv) q++;
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input int n, input bit fs);
        frame_start(fs);
        frame_body(n, fs);
    endtask

    task automatic rearm(input int init);
        cfg_enable = 1'b0;
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        cfg_thr_init = 8'(init);
        cfg_enable   = 1'b1;
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        int d0;
        rst_n          = 1'b0;
        dp.TVALID_in   = 1'b0;
        dp.in_V_SYNC   = 1'b0;
        dp.in_data_en  = 1'b0;
        dp.Feature_val = 1'b0;
        cfg_thr_init   = 8'd60;
        cfg_target     = 10'd100;
        cfg_tol        = 10'd10;
        cfg_step       = 8'd5;
        cfg_enable     = 1'b0;
        n_done         = 0;
        obs_fcnt       = -1;
        obs_thr        = -1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_thr", dp.threshold, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_state", state_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cfg_enable = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        frame_start(1'b0);
        chk("arm_thr", dp.threshold, 60);
        chk("arm_state", state_o, 2);
        chk("arm_done", frame_done, 0);
        frame_body(150, 1'b0);

        run_frame(100, 1'b0);
        chk("f150_cnt", obs_fcnt, 150);
        chk("f150_thr", obs_thr, AUTO ? 65 : 60);
        run_frame(50, 1'b0);
        chk("f100_cnt", obs_fcnt, 100);
        chk("f100_thr", obs_thr, AUTO ? 65 : 60);
        run_frame(0, 1'b0);
        chk("f50_cnt", obs_fcnt, 50);
        chk("f50_thr", obs_thr, AUTO ? 60 : 60);

        rearm(198);
        run_frame(500, 1'b0);
        run_frame(0, 1'b0);
        chk("clamp_max", obs_thr, AUTO ? 200 : 198);
        rearm(10);
        run_frame(0, 1'b0);
        d0 = n_done;
        run_frame(12, 1'b0);
        chk("zero_done", n_done, d0 + 1);
        chk("zero_cnt", obs_fcnt, 0);
        chk("clamp_min", obs_thr, AUTO ? 8 : 10);

        d0 = n_done;
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("stall_nodone", n_done, d0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        frame_body(3, 1'b0);
        chk("stall_one", n_done, d0 + 1);
        chk("stall_cnt", obs_fcnt, 12);

        run_frame(20, 1'b0);
        run_frame(7, 1'b1);
        chk("fs_excl", obs_fcnt, 20);
        run_frame(1029, 1'b0);
        chk("fs_incl", obs_fcnt, 7);
        run_frame(2, 1'b0);
        chk("sat", obs_fcnt, CMAX);

        d0 = n_done;
        cfg_enable = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("dis_state", state_o, 0);
        cfg_thr_init = 8'd77;
        cfg_enable   = 1'b1;
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1);
        frame_start(1'b1);
        chk("reload_thr", dp.threshold, 77);
        frame_body(5, 1'b0);
        chk("dis_nodone", n_done, d0);
        run_frame(9, 1'b0);
        chk("reen_cnt", obs_fcnt, 5);

        for (int i = 0; i < 8; i++) begin
            cfg_target   = 10'($urandom_range(0, 300));
            cfg_tol      = 10'($urandom_range(0, 120));
            cfg_step     = 8'($urandom_range(0, 60));
            cfg_thr_init = 8'($urandom_range(0, 255));
            run_frame(int'($urandom_range(0, 300)), 1'($urandom % 2));
        end

        frame_start(1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_thr", dp.threshold, 0);
        chk("arst_fcnt", frame_cnt, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_state", state_o, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cfg_thr_init = 8'd42;
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(4, 1'b0);
        chk("post_rst_thr", dp.threshold, 42);
        run_frame(0, 1'b0);
        chk("post_rst_cnt", obs_fcnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fast_thr_frame_ctrl.md
Name: fast_thr_frame_ctrl

Overview:
- Per-frame controller for the FAST feature-point datapath.
- Counts feature points accepted in each frame and reports the count at the frame boundary.
- Drives the datapath's 8-bit `threshold` input, changing it only between frames.
- With auto-threshold compiled in, steers the threshold so the per-frame count approaches a programmed target.

Parameters:
- CNT_W, 20, width of the per-frame feature counter and of the target/tolerance inputs.
- THR_MIN, 8, lowest threshold the auto-adjust may produce.
- THR_MAX, 200, highest threshold the auto-adjust may produce.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- TVALID_in  in  1  pipeline advance qualifier (same signal that drives the datapath).
- in_V_SYNC  in  1  frame sync, aligned to the datapath output; rising edge = frame start.
- in_data_en  in  1  active-pixel enable, aligned to the datapath output.
- Feature_val  in  1  feature flag from the datapath.
- cfg_thr_init  in  8  threshold used for the first frame and in fixed mode.
- cfg_target  in  CNT_W  desired features per frame.
- cfg_tol  in  CNT_W  dead band around the target.
- cfg_step  in  8  threshold increment/decrement per frame.
- cfg_enable  in  1  controller run enable.
- threshold  out  8  threshold to the datapath.
- frame_cnt  out  CNT_W  feature count of the last completed frame.
- frame_done  out  1  one-cycle pulse when frame_cnt updates.
- state_o  out  2  current FSM state (debug).

Behaviour:
- Reset values: threshold=cfg_thr_init is NOT used at reset; threshold=0, frame_cnt=0, frame_done=0, state=IDLE, internal counter=0, V_SYNC edge register=0.
- Frame start is detected as in_V_SYNC=1 with the registered previous V_SYNC=0.
- The edge register updates only on cycles with TVALID_in=1, so stalls never create or hide edges.
- Counting: cnt increments when TVALID_in & in_data_en & Feature_val, in ACTIVE only. It saturates at all-ones with no wrap.
- FSM states: IDLE(0), ARM(1), ACTIVE(2), UPDATE(3).
  - IDLE: wait for cfg_enable=1 → ARM.
  - ARM: wait for a frame start. On that cycle: threshold<=cfg_thr_init, cnt<=0 → ACTIVE.
  - ACTIVE: count. On the next frame start → UPDATE. The feature on the start cycle itself is counted into the new frame, not the closing one.
  - UPDATE: exactly one cycle, entered regardless of TVALID_in.
    - frame_cnt<=final cnt, frame_done=1.
    - cnt<=0, plus 1 if a qualifying feature is present this cycle.
    - Compute the new threshold (below) → ACTIVE.
- Threshold rule in UPDATE, using CNT_W+1-bit arithmetic so target+tol cannot overflow:
  - If cnt > target+tol: threshold = min(threshold+step, THR_MAX). The 9-bit sum is clamped.
  - Else if target ≥ tol and cnt < target−tol: threshold = max(threshold−step, THR_MIN). Guard the underflow: if step > threshold, result = THR_MIN.
  - Else hold.
- Threshold never changes in ACTIVE or ARM except at the ARM→ACTIVE load. This guarantees one threshold per frame.
- Latency: frame_done is asserted 1 cycle after the frame-start cycle; the new threshold is visible on the same cycle as frame_done.
- cfg_enable deasserted in any state: at the next clock → IDLE. threshold and frame_cnt hold, cnt clears, no frame_done pulse.
- cfg_enable reasserted: restarts from ARM, reloading cfg_thr_init at the next frame start.
- cfg_target, cfg_tol and cfg_step are sampled only in UPDATE. Changes mid-frame take effect at the next boundary.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous).
- A frame with zero features completes with frame_cnt=0 and frame_done pulses normally.

Optional Feature:
- Macro: FAST_AUTO_THR_EN.
- Defined: threshold adapts per the UPDATE rule above.
- Undefined: the UPDATE rule is removed and threshold is loaded from cfg_thr_init at every frame start. Counting and frame_done behave as when defined.

Test Plan:
- Reset then cfg_enable=1, cfg_thr_init=60, first V_SYNC rise → threshold=60 one cycle later, state=ACTIVE, frame_done=0.
- target=100, tol=10, step=5, thr=60; frame with 150 features → frame_done pulse, frame_cnt=150, threshold=65. A 100-feature frame → hold 65. A 50-feature frame → 60.
- thr=198, step=5, 500 features → threshold=200 (THR_MAX clamp). thr=10, step=5, 0 features → threshold=8 (THR_MIN clamp).
- TVALID_in low for 20 cycles across a V_SYNC rise, with Feature_val held high → no count increments and no edge until TVALID_in=1. Then exactly one frame_done pulse.
- Feature_val on the frame-start cycle → counted in the new frame (previous frame_cnt excludes it, next includes it). Drive 2^CNT_W+3 features → frame_cnt saturates at all-ones.
- cfg_enable dropped mid-frame, then raised → no frame_done. Next V_SYNC reloads cfg_thr_init. Build without FAST_AUTO_THR_EN: a 150-feature frame leaves threshold=cfg_thr_init.
